// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Wide unsigned adder (4*NIBBLES bits) built from a single 4-bit add slice,
// one nibble per clock, LSB nibble first, with the carry registered between
// slices. The issuing block sees a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE; once accepted, busy is
// high for NIBBLES cycles, then done pulses high for exactly one cycle and
// sum/cout (and ovf) are valid from that cycle until the next completion.
// start while busy is dropped, never queued. clear aborts a running
// operation without a done pulse and without touching the result.
//
// Optional build macro: SERIAL_ADD_OVF_EN adds the ovf output (signed
// two's-complement overflow of the W-bit add).
//
// dbg_state mirrors the FSM state register for observation only.

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [1:0]             dbg_state
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_sh_q;
    logic [W-1:0]    b_sh_q;
    logic [W-1:0]    psum_q;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;

    // Slice result and the partial sum including the nibble produced this cycle.
    logic [4:0]      slice_d;
    logic [W-1:0]    psum_d;
    logic            last_d;
    logic            c_into_msb_d;
    logic [CW+1:0]   nib_base_d;

    // One 4-bit add slice; the carry into bit 3 of the slice is recovered
    // from the operand and sum bits (a ^ b ^ s) for the overflow flag.
    always_comb begin
        slice_d      = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
        c_into_msb_d = a_sh_q[3] ^ b_sh_q[3] ^ slice_d[3];
        last_d       = (cnt_q == LAST_CNT);
        // The nibble for slice cnt_q is written at its final position, which is
        // where a right-shifting partial-sum register would have it after
        // NIBBLES shifts; every register bit is thereby meaningful.
        nib_base_d   = {cnt_q, 2'b00};
        psum_d       = psum_q;
        psum_d[nib_base_d +: 4] = slice_d[3:0];
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
`endif

    // Control FSM with all operand, carry, count and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // clear has no meaning here; start alone decides.
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        psum_q  <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    done_q <= 1'b0;
                    if (clear) begin
                        // Abort wins over a final-slice transfer; result untouched.
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        a_sh_q  <= a_sh_q >> 4;
                        b_sh_q  <= b_sh_q >> 4;
                        psum_q  <= psum_d;
                        carry_q <= slice_d[4];
                        cnt_q   <= cnt_q + 1'b1;
                        if (last_d) begin
                            sum_q   <= psum_d;
                            cout_q  <= slice_d[4];
`ifdef SERIAL_ADD_OVF_EN
                            ovf_q   <= c_into_msb_d ^ slice_d[4];
`endif
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    // A start here chains directly into the next operation.
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        psum_q  <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy      = busy_q;
        done      = done_q;
        sum       = sum_q;
        cout      = cout_q;
        dbg_state = state_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf       = ovf_q;
`endif
    end

`ifndef SERIAL_ADD_OVF_EN
    // Carry into the MSB only feeds the optional overflow flag.
    logic unused_c_into_msb;
    always_comb unused_c_into_msb = c_into_msb_d;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4, W=16).
// Table vectors, hand-written multi-cycle sequences and random operations
// checked against an arithmetic reference model through an expected queue.

module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         clear;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_state;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .dbg_state (dbg_state)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Entry layout: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];
    int           total;
    int           bad;
    logic [W-1:0] last_sum;
    logic         last_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic plus the sign rule for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {o, t[W], t[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [W+1:0] e);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done; k=0 is the first negedge reached.
    task automatic wait_done(output int lat, output int bc);
        int  k;
        bit  got;
        k = 0; got = 0; bc = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (busy) bc++;
                k++;
            end
        end
        lat = k;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string nm);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_sum"}, 64'(sum), 64'(e[W-1:0]));
            chk({nm, "_cout"}, 64'(cout), 64'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
            chk({nm, "_ovf"}, 64'(ovf), 64'(e[W+1]));
`endif
            last_sum  = e[W-1:0];
            last_cout = e[W];
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W+1:0] e);
        int lat, bc;
        start_op(x, y, c, e);
        wait_done(lat, bc);
        chk({nm, "_latency"}, 64'(lat), 64'(NIBBLES));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(NIBBLES));
        check_result(nm);
        @(negedge clk);
        chk({nm, "_done_width"}, 64'(done), 64'd0);
        chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat, bc, dcnt;
        logic [W-1:0] x, y;
        logic c;

        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; a = '0; b = '0; cin = 1'b0;
        last_sum = '0; last_cout = 1'b0;

        vecs[0] = '{16'h0000, 16'h000A, 1'b0, 16'h000A, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h8ACD, 1'b1, 16'h9D02, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   {vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum});

        // Back-to-back: start held during DONE, no IDLE cycle between runs
        start_op(16'h1234, 16'h8ACD, 1'b1, {1'b0, 1'b0, 16'h9D02});
        wait_done(lat, bc);
        chk("b2b_first_latency", 64'(lat), 64'(NIBBLES));
        check_result("b2b_first");
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back({1'b0, 1'b0, 16'h0002});
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle_busy", 64'(busy), 64'd1);
        chk("b2b_no_second_done", 64'(done), 64'd0);
        wait_done(lat, bc);
        chk("b2b_second_latency", 64'(lat), 64'(NIBBLES - 1));
        check_result("b2b_second");
        @(negedge clk);

        // start while busy is ignored
        start_op(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
        @(negedge clk);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        chk("ign_latency", 64'(lat), 64'(NIBBLES - 2));
        check_result("ign");
        @(negedge clk);
        chk("ign_no_rerun", 64'(busy), 64'd0);

        // clear on the 3rd RUN cycle aborts, result unchanged
        start_op(16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        dcnt = 0;
        repeat (NIBBLES + 2) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("clr_no_done", 64'(dcnt), 64'd0);
        chk("clr_sum_hold", 64'(sum), 64'(last_sum));
        chk("clr_cout_hold", 64'(cout), 64'(last_cout));
        run_op("after_clr", 16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0));

        // clear on the final slice cycle beats the transfer
        start_op(16'hFFFF, 16'hFFFF, 1'b0, model(16'hFFFF, 16'hFFFF, 1'b0));
        repeat (NIBBLES) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("clr_last_done", 64'(done), 64'd0);
        chk("clr_last_busy", 64'(busy), 64'd0);
        chk("clr_last_sum_hold", 64'(sum), 64'(last_sum));
        chk("clr_last_cout_hold", 64'(cout), 64'(last_cout));

        // clear together with start in IDLE: start wins
        @(negedge clk);
        a = 16'h0F00; b = 16'h0100; cin = 1'b1; start = 1'b1; clear = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(16'h0F00, 16'h0100, 1'b1));
        #1 begin start = 1'b0; clear = 1'b0; end
        wait_done(lat, bc);
        chk("idle_clr_start_latency", 64'(lat), 64'(NIBBLES));
        check_result("idle_clr_start");
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        start_op(16'h0102, 16'h0304, 1'b0, model(16'h0102, 16'h0304, 1'b0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_sum", 64'(sum), 64'd0);
        chk("arst_cout", 64'(cout), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_arst", 16'hBEEF, 16'h1234, 1'b1, model(16'hBEEF, 16'h1234, 1'b1));

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom());
            y = W'($urandom());
            c = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), x, y, c, model(x, y, c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs a wide addition (4*NIBBLES bits) by reusing one 4-bit add slice, one nibble per clock, LSB nibble first. Carry is registered between slices. Simple start/busy/done handshake toward the issuing block. Sits between a control FSM or host interface and the 4-bit adder datapath, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when the block can accept
clear  input  1  synchronous abort of an in-flight operation
a  input  W  operand A, sampled on the accepted start
b  input  W  operand B, sampled on the accepted start
cin  input  1  carry-in, sampled on the accepted start
busy  output  1  high while the operation is in progress (RUN)
done  output  1  one-cycle pulse; sum/cout are valid from this cycle on
sum  output  W  registered result
cout  output  1  registered carry-out of the MSB nibble

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand/carry/count registers=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a, b, cin into shift registers; carry_reg=cin; count=0; go RUN. start=0 -> stay.
- RUN (busy=1): each cycle, slice = a_sh[3:0] + b_sh[3:0] + carry_reg (5-bit result). Low 4 bits shift into the top of the partial-sum register. a_sh and b_sh shift right by 4. carry_reg <= slice[4]. count increments.
- RUN exit: on the cycle that processes slice NIBBLES-1, the full partial sum is transferred to sum, cout <= final carry, and the state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE. If start=1 in DONE, it is accepted as in IDLE and the next state is RUN (back-to-back operation).
- Latency: start accepted at edge T; done is high in the cycle after edge T+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- sum/cout change only on the RUN->DONE transfer. They hold their value through IDLE, RUN, aborts, and new starts. Intermediate nibbles are never visible.
- start while busy=1: ignored; no queuing.
- clear: valid in RUN only. The next state is IDLE, no done pulse is produced, and sum/cout stay unchanged. clear has priority over the final-slice transfer. clear in IDLE or DONE has no effect; in DONE, start is still honoured.
- clear and start in the same cycle while in IDLE: start wins (clear is ignored in IDLE).
- rst_n low mid-operation: immediate return to reset values; the operation is lost.
- Arithmetic is unsigned modulo 2^W. cout is the true carry out of bit W-1.
- NIBBLES=1: RUN lasts one cycle; latency is 2 cycles.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0). It is the signed two's-complement overflow of the W-bit add, computed on the last slice as carry into bit W-1 XOR carry out of bit W-1. It updates with sum/cout only and holds otherwise.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- NIBBLES=4, reset then start with a=0x0000, b=0x000A, cin=0 -> busy for 4 cycles; done pulses 5 cycles after the accepting edge; sum=0x000A, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all nibbles). With SERIAL_ADD_OVF_EN, also a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- a=0x1234, b=0x8ACD, cin=1 -> sum=0x9D02, cout=0. Then start held high during DONE with a=0x0001, b=0x0001, cin=0 -> back-to-back run giving sum=0x0002, with no IDLE cycle in between.
- Start, then pulse start again on the 2nd RUN cycle with different operands -> second start ignored; the result matches the first operands only.
- Start, then assert clear on the 3rd RUN cycle -> IDLE next cycle, no done, sum/cout keep the previous result. A subsequent start completes normally.
- Drive rst_n low mid-RUN asynchronously (between clock edges) -> busy, done, sum and cout go to 0 immediately. After release, a new operation completes correctly.
